// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: stage 1 holds the operand beat, stage 2 evaluates
// the branch condition and holds the taken/target result for the consumer.

// Fixed 32-bit comparator providing signed equality/ordering flags.
module signed_comparator (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        aEqB,
    output logic        aLtB,
    output logic        aGtB
);
    assign aEqB = (a == b);
    assign aLtB = ($signed(a) < $signed(b));
    assign aGtB = ($signed(a) > $signed(b));
endmodule

module branch_resolve_unit #(
    parameter int W    = 32,
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [W-1:0]    in_pc,
    input  logic [W-1:0]    in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [W-1:0]    out_target,
    output logic            out_illegal
);
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b000;
    localparam logic [OP_W-1:0] OP_BNE  = 3'b001;
    localparam logic [OP_W-1:0] OP_BLT  = 3'b100;
    localparam logic [OP_W-1:0] OP_BGE  = 3'b101;
    localparam logic [OP_W-1:0] OP_BLTU = 3'b110;
    localparam logic [OP_W-1:0] OP_BGEU = 3'b111;

    logic            s1Valid;
    logic [OP_W-1:0] s1Op;
    logic [W-1:0]    s1A;
    logic [W-1:0]    s1B;
    logic [W-1:0]    s1Pc;
    logic [W-1:0]    s1Imm;

    logic            s2Valid;
    logic            s2Taken;
    logic [W-1:0]    s2Target;
    logic            s2Illegal;

    logic            s1Adv;
    logic            s2Adv;
    logic            aEqB;
    logic            aLtB;
    logic            aGtB;
    logic            aLtuB;
    logic            condTrue;
    logic            opIllegal;
    logic [W-1:0]    nextTarget;

    // Output stage frees up when empty or being drained; the input stage
    // frees up when empty or able to move into stage 2 in the same edge.
    assign s2Adv    = !s2Valid || out_ready;
    assign s1Adv    = !s1Valid || s2Adv;
    assign in_ready = s1Adv && !flush;

    signed_comparator uCmp (
        .a    (s1A),
        .b    (s1B),
        .aEqB (aEqB),
        .aLtB (aLtB),
        .aGtB (aGtB)
    );

    assign aLtuB = (s1A < s1B);

    // Branch condition decode; undefined codes fall through as not-taken.
    always_comb begin
        condTrue  = 1'b0;
        opIllegal = 1'b0;
        case (s1Op)
            OP_BEQ:  condTrue = aEqB;
            OP_BNE:  condTrue = !aEqB;
            OP_BLT:  condTrue = aLtB;
            OP_BGE:  condTrue = aGtB || aEqB;
            OP_BLTU: condTrue = aLtuB;
            OP_BGEU: condTrue = !aLtuB;
            default: opIllegal = 1'b1;
        endcase
        nextTarget = condTrue ? (s1Pc + s1Imm) : (s1Pc + W'(4));
    end

    // Stage 1: capture an operand beat whenever the stage can advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Op    <= '0;
            s1A     <= '0;
            s1B     <= '0;
            s1Pc    <= '0;
            s1Imm   <= '0;
        end else if (flush) begin
            s1Valid <= 1'b0;
        end else if (s1Adv) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Op  <= in_op;
                s1A   <= in_a;
                s1B   <= in_b;
                s1Pc  <= in_pc;
                s1Imm <= in_imm;
            end
        end
    end

    // Stage 2: register the resolved branch; result held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid   <= 1'b0;
            s2Taken   <= 1'b0;
            s2Target  <= '0;
            s2Illegal <= 1'b0;
        end else if (flush) begin
            s2Valid <= 1'b0;
        end else if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Taken   <= condTrue;
                s2Target  <= nextTarget;
                s2Illegal <= opIllegal;
            end
        end
    end

    assign out_valid   = s2Valid;
    assign out_taken   = s2Taken;
    assign out_target  = s2Target;
    assign out_illegal = s2Illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, hand
// sequences for stall/flush/reset, and a random stream against a scoreboard.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_illegal;

    branch_resolve_unit #(.W(32), .OP_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_taken   (out_taken),
        .out_target  (out_target),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        illegal;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        expTaken;
        logic [31:0] expTarget;
        logic        expIllegal;
    } vec_t;

    res_t q[$];
    int   vecs = 0;
    int   miss = 0;
    int   accCnt = 0;
    int   delCnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: RISC-V branch semantics written directly with arithmetic.
    function automatic res_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc,
                                   input logic [31:0] imm);
        res_t r;
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        r.illegal = 1'b0;
        r.taken   = 1'b0;
        case (op)
            3'd0: r.taken = (a == b);
            3'd1: r.taken = (a != b);
            3'd4: r.taken = (sa < sb);
            3'd5: r.taken = (sa >= sb);
            3'd6: r.taken = (a < b);
            3'd7: r.taken = (a >= b);
            default: r.illegal = 1'b1;
        endcase
        r.target = r.taken ? pc + imm : pc + 32'd4;
        return r;
    endfunction

    // One clock cycle; entered at a falling edge with inputs already driven.
    task automatic step();
        logic expReady;
        res_t r;
        #1;
        expReady = !flush && ((q.size() < 2) || out_ready);
        chk("in_ready", {31'b0, in_ready}, {31'b0, expReady});
        if (out_valid && q.size() == 0)
            chk("no_phantom_output", {31'b0, out_valid}, 32'd0);
        if (out_valid && out_ready && q.size() > 0) begin
            r = q.pop_front();
            chk("sb_taken",   {31'b0, out_taken},   {31'b0, r.taken});
            chk("sb_target",  out_target,           r.target);
            chk("sb_illegal", {31'b0, out_illegal}, {31'b0, r.illegal});
            delCnt++;
        end
        if (in_valid && in_ready && !flush) begin
            q.push_back(model(in_op, in_a, in_b, in_pc, in_imm));
            accCnt++;
        end
        @(posedge clk);
        if (flush) q.delete();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain_empty", q.size(), 32'd0);
    endtask

    task automatic randBeat(input bit legalOnly);
        int sel;
        in_a   = $urandom;
        in_b   = ($urandom_range(3) == 0) ? in_a : $urandom;
        in_pc  = $urandom;
        in_imm = $urandom;
        if (legalOnly) begin
            sel   = $urandom_range(5);
            in_op = (sel < 2) ? 3'(sel) : 3'(sel + 2);
        end else begin
            in_op = 3'($urandom_range(7));
        end
    endtask

    vec_t tbl[10];

    initial begin
        int startAcc;
        int startDel;
        int c;

        tbl[0] = '{3'd4, 32'd10,        32'hFFFFFFF6, 32'h100,      32'h20,       1'b0, 32'h104, 1'b0};
        tbl[1] = '{3'd4, 32'hFFFFFFF6,  32'd10,       32'h100,      32'hFFFFFFF8, 1'b1, 32'hF8,  1'b0};
        tbl[2] = '{3'd6, 32'hFFFFFFF6,  32'd10,       32'h100,      32'hFFFFFFF8, 1'b0, 32'h104, 1'b0};
        tbl[3] = '{3'd5, 32'hFFFFFFF6,  32'hFFFFFFEC, 32'h200,      32'h40,       1'b1, 32'h240, 1'b0};
        tbl[4] = '{3'd0, 32'h80000000,  32'h80000000, 32'h300,      32'h10,       1'b1, 32'h310, 1'b0};
        tbl[5] = '{3'd1, 32'h80000000,  32'h80000000, 32'h300,      32'h10,       1'b0, 32'h304, 1'b0};
        tbl[6] = '{3'd2, 32'd1,         32'd1,        32'hFFFFFFFC, 32'h20,       1'b0, 32'h0,   1'b1};
        tbl[7] = '{3'd0, 32'd5,         32'd5,        32'hFFFFFFF0, 32'h20,       1'b1, 32'h10,  1'b0};
        tbl[8] = '{3'd7, 32'd3,         32'hFFFFFFFF, 32'h400,      32'h80,       1'b0, 32'h404, 1'b0};
        tbl[9] = '{3'd5, 32'hFFFFFFEC,  32'hFFFFFFEC, 32'h500,      32'hFFFFFF00, 1'b1, 32'h400, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid",   {31'b0, out_valid},   32'd0);
        chk("rst_out_taken",   {31'b0, out_taken},   32'd0);
        chk("rst_out_target",  out_target,           32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed vectors with two-edge latency check.
        for (int i = 0; i < 10; i++) begin
            in_op = tbl[i].op; in_a = tbl[i].a; in_b = tbl[i].b;
            in_pc = tbl[i].pc; in_imm = tbl[i].imm;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk("lat_not_early", {31'b0, out_valid}, 32'd0);
            step();
            chk("lat_valid",   {31'b0, out_valid},   32'd1);
            chk("tbl_taken",   {31'b0, out_taken},   {31'b0, tbl[i].expTaken});
            chk("tbl_target",  out_target,           tbl[i].expTarget);
            chk("tbl_illegal", {31'b0, out_illegal}, {31'b0, tbl[i].expIllegal});
            step();
        end
        drain();

        // Stream of 8 beats with out_ready pattern 1,0,0,1.
        startAcc = accCnt;
        startDel = delCnt;
        c = 0;
        while (c < 80 && accCnt - startAcc < 8) begin
            randBeat(1'b1);
            in_valid  = 1'b1;
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            c++;
        end
        chk("stream_accepted", accCnt - startAcc, 32'd8);
        drain();
        chk("stream_delivered", delCnt - startDel, 32'd8);

        // Flush with two beats in flight and the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        randBeat(1'b1); step();
        randBeat(1'b1); step();
        chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        randBeat(1'b1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", {31'b0, out_valid}, 32'd0);
        end

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op = 3'd0; in_a = 32'd7; in_b = 32'd7; in_pc = 32'h1000; in_imm = 32'h40;
        step();
        randBeat(1'b1);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_taken", {31'b0, out_taken}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid",   {31'b0, out_valid},   32'd0);
        chk("mid_rst_taken",   {31'b0, out_taken},   32'd0);
        chk("mid_rst_target",  out_target,           32'd0);
        chk("mid_rst_illegal", {31'b0, out_illegal}, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_mid_rst_valid", {31'b0, out_valid}, 32'd0);

        // Random traffic with backpressure, illegal ops and occasional flush.
        for (int i = 0; i < 400; i++) begin
            randBeat(1'b0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            flush     = ($urandom_range(29) == 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
